// File: rtl/dsm_osr_sequencer.sv
// dsm_osr_sequencer
//   Feeds a delta-sigma modulator with an oversampled copy of a sample-rate
//   stream. Incoming samples are queued in a small FIFO. Each sample is then
//   held for cfg_osr modulator beats (a zero-order hold), and the modulator
//   reset is sequenced around the run.
//
//   Optional feature: define DSM_SEQ_SOFT_MUTE_EN to build in a MUTE state.
//   On disable, MUTE ramps the held sample down by arithmetic right shifts
//   (one step per sample period), outputs one period of zero, and then
//   returns to IDLE. Without the macro, disable returns straight to IDLE.
//
// Ports
//   aclk           clock, rising edge
//   arst_n         synchronous active-low reset
//   cfg_enable     run request (level)
//   cfg_osr        beats per input sample (0 behaves as 1)
//   s_axis_*       sample-rate input stream (signed tdata)
//   m_axis_*       beat-rate output stream to the modulator (registered)
//   mod_rst_n      registered active-low modulator reset
//   underrun       sticky: FIFO was empty at a sample boundary
//   busy           state is not IDLE
module dsm_osr_sequencer #(
  parameter int WIDTH      = 16,
  parameter int OSR_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic                    cfg_enable,
  input  logic [OSR_W-1:0]        cfg_osr,
  input  logic signed [WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic signed [WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    mod_rst_n,
  output logic                    underrun,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef DSM_SEQ_SOFT_MUTE_EN
  localparam int KW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_MUTE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;
`endif

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    mrst_n_q, mrst_n_d;
  logic                    underrun_q, underrun_d;
  logic [OSR_W-1:0]        beat_q, beat_d;
  logic [OSR_W-1:0]        limit_q, limit_d;
`ifdef DSM_SEQ_SOFT_MUTE_EN
  logic [KW-1:0]           k_q, k_d;
`endif

  logic                    push, pop, flush, full, consumed, boundary;
  logic signed [WIDTH-1:0] head;

  // An OSR of zero would never reach a boundary, so it runs as one beat.
  function automatic logic [OSR_W-1:0] osr_limit(input logic [OSR_W-1:0] osr);
    return (osr == '0) ? OSR_W'(1) : osr;
  endfunction

`ifdef DSM_SEQ_SOFT_MUTE_EN
  // Shift steps beyond WIDTH form the trailing zero period of the ramp.
  function automatic logic signed [WIDTH-1:0] mute_scale(
    input logic signed [WIDTH-1:0] v,
    input logic [KW-1:0]           k
  );
    if (k > KW'(WIDTH)) return '0;
    return v >>> k;
  endfunction
`endif

  assign head          = mem_q[rd_q];
  assign full          = (cnt_q == CW'(FIFO_DEPTH));
  assign consumed      = tvalid_q & m_axis_tready;
  assign boundary      = consumed && (beat_q == limit_q - OSR_W'(1));
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign mod_rst_n     = mrst_n_q;
  assign underrun      = underrun_q;
  assign busy          = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    mrst_n_d      = mrst_n_q;
    underrun_d    = underrun_q;
    beat_d        = beat_q;
    limit_d       = limit_q;
`ifdef DSM_SEQ_SOFT_MUTE_EN
    k_d           = k_q;
`endif
    pop           = 1'b0;
    flush         = 1'b0;

    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        mrst_n_d = 1'b0;
        beat_d   = '0;
        if (cfg_enable) begin
          state_d    = S_PRIME;
          underrun_d = 1'b0;
        end
      end

      S_PRIME: begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        mrst_n_d = 1'b0;
        beat_d   = '0;
        if (!cfg_enable) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (cnt_q >= CW'(2)) begin
          state_d  = S_RUN;
          pop      = 1'b1;
          hold_d   = head;
          tdata_d  = head;
          tvalid_d = 1'b1;
          mrst_n_d = 1'b1;
          limit_d  = osr_limit(cfg_osr);
        end
      end

      S_RUN: begin
        if (!cfg_enable) begin
`ifdef DSM_SEQ_SOFT_MUTE_EN
          state_d = S_MUTE;
          k_d     = KW'(1);
          beat_d  = '0;
          tdata_d = mute_scale(hold_q, KW'(1));
`else
          state_d  = S_IDLE;
          flush    = 1'b1;
          tvalid_d = 1'b0;
          tdata_d  = '0;
          mrst_n_d = 1'b0;
          beat_d   = '0;
`endif
        end else if (boundary) begin
          beat_d  = '0;
          limit_d = osr_limit(cfg_osr);
          if (cnt_q != '0) begin
            pop     = 1'b1;
            hold_d  = head;
            tdata_d = head;
          end else begin
            // Starved: repeat the held sample and flag it.
            underrun_d = 1'b1;
          end
        end else if (consumed) begin
          beat_d = beat_q + OSR_W'(1);
        end
      end

`ifdef DSM_SEQ_SOFT_MUTE_EN
      S_MUTE: begin
        // Enable is deliberately ignored until the ramp finishes.
        if (boundary) begin
          beat_d  = '0;
          limit_d = osr_limit(cfg_osr);
          if (k_q == KW'(WIDTH + 1)) begin
            state_d  = S_IDLE;
            flush    = 1'b1;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            mrst_n_d = 1'b0;
          end else begin
            k_d     = k_q + KW'(1);
            tdata_d = mute_scale(hold_q, k_q + KW'(1));
          end
        end else if (consumed) begin
          beat_d = beat_q + OSR_W'(1);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // A pop frees a slot in the same cycle, so a full FIFO can still take a
    // sample on the cycle it is read.
    s_axis_tready = arst_n & (~full | pop);
    push          = s_axis_tvalid & s_axis_tready;

    wr_d = wr_q + AW'(push);
    if (flush) begin
      // Drop everything queued, but keep a sample arriving on this edge.
      rd_d  = wr_q;
      cnt_d = CW'(push);
    end else begin
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      mrst_n_q   <= 1'b0;
      underrun_q <= 1'b0;
      beat_q     <= '0;
      limit_q    <= OSR_W'(1);
`ifdef DSM_SEQ_SOFT_MUTE_EN
      k_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      mrst_n_q   <= mrst_n_d;
      underrun_q <= underrun_d;
      beat_q     <= beat_d;
      limit_q    <= limit_d;
`ifdef DSM_SEQ_SOFT_MUTE_EN
      k_q        <= k_d;
`endif
    end
  end

  // FIFO storage
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_q] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_dsm_osr_sequencer.sv
module tb_dsm_osr_sequencer;

  logic               aclk = 1'b0;
  logic               arst_n;
  logic               cfg_enable;
  logic [7:0]         cfg_osr;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               mod_rst_n;
  logic               underrun;
  logic               busy;

  int n_checks = 0;
  int n_err    = 0;

  dsm_osr_sequencer #(.WIDTH(16), .OSR_W(8), .FIFO_DEPTH(4)) dut (
    .aclk          (aclk),
    .arst_n        (arst_n),
    .cfg_enable    (cfg_enable),
    .cfg_osr       (cfg_osr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .mod_rst_n     (mod_rst_n),
    .underrun      (underrun),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic               en;
    logic               tv;
    logic signed [15:0] td;
    logic               tr;
    logic               e_vld;
    logic signed [15:0] e_data;
    logic               e_mrst;
    logic               e_busy;
    logic               e_und;
    logic               e_rdy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic en, input logic tv, input int td,
                              input logic vld, input int data, input logic mrst,
                              input logic bsy, input logic und);
    vec_t v;
    v.en = en; v.tv = tv; v.td = 16'(td); v.tr = 1'b1;
    v.e_vld = vld; v.e_data = 16'(data); v.e_mrst = mrst;
    v.e_busy = bsy; v.e_und = und; v.e_rdy = 1'b1;
    return v;
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, return at
  // the next falling edge where outputs are stable.
  task automatic step(input int en, input int tv, input int td, input int tr);
    cfg_enable    = (en != 0);
    s_axis_tvalid = (tv != 0);
    s_axis_tdata  = 16'(td);
    m_axis_tready = (tr != 0);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chkd(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    arst_n = 1'b1;
    step(0, 0, 0, 1);
  endtask

  initial begin
    arst_n = 1'b0; cfg_enable = 1'b0; cfg_osr = 8'd4;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk1("rst_tvalid", m_axis_tvalid, 1'b0);
    chkd("rst_tdata", int'(m_axis_tdata), 0);
    chk1("rst_mod_rst_n", mod_rst_n, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s_ready", s_axis_tready, 1'b0);
    arst_n = 1'b1;
    step(0, 0, 0, 1);
    chk1("rel_s_ready", s_axis_tready, 1'b1);

    // osr=4, samples 100/200/300: four beats each, then starvation
    tbl[0]  = mk(0, 1, 100, 0, 0,   0, 0, 0);
    tbl[1]  = mk(0, 1, 200, 0, 0,   0, 0, 0);
    tbl[2]  = mk(1, 1, 300, 0, 0,   0, 1, 0);
    tbl[3]  = mk(1, 0, 0,   1, 100, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0,   1, 100, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0,   1, 100, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0,   1, 100, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0,   1, 200, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0,   1, 200, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0,   1, 200, 1, 1, 0);
    tbl[10] = mk(1, 0, 0,   1, 200, 1, 1, 0);
    tbl[11] = mk(1, 0, 0,   1, 300, 1, 1, 0);
    tbl[12] = mk(1, 0, 0,   1, 300, 1, 1, 0);
    tbl[13] = mk(1, 0, 0,   1, 300, 1, 1, 0);
    tbl[14] = mk(1, 0, 0,   1, 300, 1, 1, 0);
    tbl[15] = mk(1, 0, 0,   1, 300, 1, 1, 1);
    cfg_osr = 8'd4;
    for (int i = 0; i < 16; i++) begin
      step(int'(tbl[i].en), int'(tbl[i].tv), int'(tbl[i].td), int'(tbl[i].tr));
      chk1($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].e_vld);
      chkd($sformatf("tbl%0d_tdata", i), int'(m_axis_tdata), int'(tbl[i].e_data));
      chk1($sformatf("tbl%0d_mod_rst_n", i), mod_rst_n, tbl[i].e_mrst);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("tbl%0d_underrun", i), underrun, tbl[i].e_und);
      chk1($sformatf("tbl%0d_s_ready", i), s_axis_tready, tbl[i].e_rdy);
    end

    // Reset in the middle of a run, with a sample left in the FIFO
    step(1, 1, 500, 1);
    arst_n = 1'b0;
    step(1, 0, 0, 1);
    chk1("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk1("midrst_mod_rst_n", mod_rst_n, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_underrun", underrun, 1'b0);
    chk1("midrst_s_ready", s_axis_tready, 1'b0);
    arst_n = 1'b1;
    step(0, 0, 0, 1);
    chk1("midrst_rel_s_ready", s_axis_tready, 1'b1);
    // One more sample must not be enough to start: the FIFO was emptied.
    step(1, 0, 0, 1);
    step(1, 1, 7, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk1("midrst_fifo_empty_tvalid", m_axis_tvalid, 1'b0);
    chk1("prime_busy", busy, 1'b1);
    step(0, 0, 0, 1);
    chk1("prime_disable_busy", busy, 1'b0);

    // osr=0 acts as 1: 5, 6, then 6 repeated with underrun
    cfg_osr = 8'd0;
    step(0, 1, 5, 1);
    step(0, 1, 6, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chkd("osr0_beat1", int'(m_axis_tdata), 5);
    step(1, 0, 0, 1);
    chkd("osr0_beat2", int'(m_axis_tdata), 6);
    chk1("osr0_underrun_lo", underrun, 1'b0);
    step(1, 0, 0, 1);
    chkd("osr0_beat3", int'(m_axis_tdata), 6);
    chk1("osr0_underrun_hi", underrun, 1'b1);
    do_reset();

    // osr=3 with a 5-cycle stall mid-period
    cfg_osr = 8'd3;
    step(0, 1, 11, 1);
    step(0, 1, 22, 1);
    step(0, 1, 33, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chkd("stall_first", int'(m_axis_tdata), 11);
    step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chkd($sformatf("stall_hold%0d", i), int'(m_axis_tdata), 11);
      chk1($sformatf("stall_tvalid%0d", i), m_axis_tvalid, 1'b1);
    end
    step(1, 0, 0, 1);
    chkd("stall_third_beat", int'(m_axis_tdata), 11);
    step(1, 0, 0, 1);
    chkd("stall_next_sample", int'(m_axis_tdata), 22);

`ifndef DSM_SEQ_SOFT_MUTE_EN
    // Disable in RUN: IDLE next cycle, FIFO (still holding 33) flushed
    step(0, 0, 0, 1);
    chk1("dis_tvalid", m_axis_tvalid, 1'b0);
    chkd("dis_tdata", int'(m_axis_tdata), 0);
    chk1("dis_mod_rst_n", mod_rst_n, 1'b0);
    chk1("dis_busy", busy, 1'b0);
    step(1, 0, 0, 1);
    step(1, 1, 44, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk1("dis_flushed_tvalid", m_axis_tvalid, 1'b0);
`endif
    do_reset();

    // Full FIFO: pops and pushes share a cycle, nothing is lost
    cfg_osr = 8'd2;
    step(0, 1, 1, 1);
    step(0, 1, 2, 1);
    step(0, 1, 3, 1);
    step(0, 1, 4, 1);
    chk1("full_ready_low", s_axis_tready, 1'b0);
    step(1, 1, 5, 1);
    chk1("prime_pop_ready", s_axis_tready, 1'b1);
    step(1, 1, 5, 1);
    chkd("full_first", int'(m_axis_tdata), 1);
    chk1("full_midperiod_ready", s_axis_tready, 1'b0);
    step(1, 1, 6, 1);
    chk1("full_boundary_ready", s_axis_tready, 1'b1);
    step(1, 1, 6, 1);
    chkd("full_second", int'(m_axis_tdata), 2);
    for (int s = 3; s <= 6; s++) begin
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chkd($sformatf("full_sample%0d", s), int'(m_axis_tdata), s);
    end
    chk1("full_no_underrun", underrun, 1'b0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk1("full_drained_underrun", underrun, 1'b1);

`ifdef DSM_SEQ_SOFT_MUTE_EN
    // Soft mute ramp from -32768 at osr=1
    do_reset();
    cfg_osr = 8'd1;
    step(0, 1, -32768, 1);
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chkd("mute_start", int'(m_axis_tdata), -32768);
    for (int k = 1; k <= 16; k++) begin
      step((k >= 3 && k <= 10) ? 1 : 0, 0, 0, 1);
      chkd($sformatf("mute_k%0d", k), int'(m_axis_tdata),
           (k >= 16) ? -1 : -(1 << (15 - k)));
    end
    step(0, 0, 0, 1);
    chkd("mute_zero", int'(m_axis_tdata), 0);
    chk1("mute_zero_tvalid", m_axis_tvalid, 1'b1);
    step(0, 0, 0, 1);
    chk1("mute_end_tvalid", m_axis_tvalid, 1'b0);
    chk1("mute_end_mod_rst_n", mod_rst_n, 1'b0);
    chk1("mute_end_busy", busy, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
